fifo_line_reader: RTL

Downstream consumer of the camera ping-pong line FIFOs in the `clk` domain. It drains fifo1 and fifo2 alternately, one full line each, and converts RGB565 to RGB888. It presents the pixels as a valid/ready stream with start-of-frame and end-of-line markers, which feeds the LCD pixel path in place of the tied-off `i_rgb`/`i_data_vld` inputs of `rgb_top`.

---
 rtl/cnn_pix_pkg.sv | 38 +++
 rtl/pix_skid_buf.sv | 69 ++++++
 rtl/fifo_line_reader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cnn_pix_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pix_pkg
// Shared types and helpers for the camera-to-LCD pixel path.
//   line_rd_state_e : state encoding of the line reader FSM
//   rgb565_t        : RGB565 word split into its colour fields
//   pix_t           : 26-bit skid payload {sof, eol, rgb888}
//   rgb565_to_888() : RGB565 -> RGB888 expansion by MSB replication
// -----------------------------------------------------------------------------
package cnn_pix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_SWITCH = 2'd2,
    ST_DONE   = 2'd3
  } line_rd_state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic [23:0] rgb;
  } pix_t;

  localparam int unsigned PIX_W = $bits(pix_t);

  // Replicating the top bits into the new LSBs maps full-scale 565 to
  // full-scale 888 (0x1F -> 0xFF) and zero to zero.
  function automatic logic [23:0] rgb565_to_888(input rgb565_t p);
    return {p.r, p.r[4:2], p.g, p.g[5:4], p.b, p.b[4:2]};
  endfunction

endpackage

// File: rtl/pix_skid_buf.sv
// -----------------------------------------------------------------------------
// pix_skid_buf
// Two-entry valid/ready buffer holding tagged pixels between the FIFO read
// port and the downstream consumer. The producer never pushes into a full
// buffer (the reader throttles itself on count_o), so nothing is dropped.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush_i      discard all held entries (frame abort)
//   in_vld_i     push in_data_i this cycle
//   in_data_i    payload {sof, eol, rgb}
//   out_vld_o    head entry valid
//   out_data_o   head entry payload (stable until popped)
//   out_rdy_i    consumer accepts head when out_vld_o && out_rdy_i
//   count_o      number of held entries (0..2)
// -----------------------------------------------------------------------------
module pix_skid_buf
  import cnn_pix_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic       in_vld_i,
  input  pix_t       in_data_i,
  output logic       out_vld_o,
  output pix_t       out_data_o,
  input  logic       out_rdy_i,
  output logic [1:0] count_o
);

  pix_t       mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       push;
  logic       pop;

  // A push into a full buffer is refused rather than overwriting the head.
  assign push = in_vld_i && (count_q != 2'd2);
  assign pop  = (count_q != 2'd0) && out_rdy_i;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: payload storage is not reset; an entry is only observed while
  // count_q marks it valid, and the top masks outputs when nothing is valid.
  always_ff @(posedge clk) begin
    if (push && !flush_i) mem_q[wr_ptr_q] <= in_data_i;
  end

  assign out_vld_o  = (count_q != 2'd0);
  assign out_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/fifo_line_reader.sv
// -----------------------------------------------------------------------------
// fifo_line_reader
// Drains the camera ping-pong line FIFOs alternately, one full line per turn,
// converts RGB565 to RGB888 and presents a valid/ready pixel stream with
// start-of-frame and end-of-line markers.
// Parameters:
//   H_ACTIVE  pixels per line (one line per FIFO turn)
//   V_ACTIVE  lines per frame
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   i_frame_start                      one-cycle pulse; arms (or re-arms) a frame
//   i_fifo1_empty, i_fifo2_empty       FIFO empty flags
//   o_fifo1_rd_en, o_fifo2_rd_en       read strobes, mutually exclusive
//   i_fifo1_rd_data, i_fifo2_rd_data   RGB565 data, valid the cycle after rd_en
//   o_rgb, o_vld, i_ready              RGB888 pixel stream
//   o_sof, o_eol                       first pixel of frame / last pixel of line
//   o_fifo_sel                         0 = fifo1 being drained, 1 = fifo2
//   o_frame_done                       pulse after the frame's last pixel is taken
// -----------------------------------------------------------------------------
module fifo_line_reader
  import cnn_pix_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_frame_start,
  input  logic        i_fifo1_empty,
  input  logic        i_fifo2_empty,
  output logic        o_fifo1_rd_en,
  output logic        o_fifo2_rd_en,
  input  logic [15:0] i_fifo1_rd_data,
  input  logic [15:0] i_fifo2_rd_data,
  output logic [23:0] o_rgb,
  output logic        o_vld,
  input  logic        i_ready,
  output logic        o_sof,
  output logic        o_eol,
  output logic        o_fifo_sel,
  output logic        o_frame_done
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  line_rd_state_e state_q;
  logic [XW-1:0]  x_q;
  logic [YW-1:0]  y_q;
  logic           sel_q;
  logic           inflight_q;    // a read was issued last cycle
  logic           infl_sof_q;    // tags travelling with that read
  logic           infl_eol_q;
  logic           frame_done_q;

  logic           skid_vld;
  logic [1:0]     skid_cnt;
  pix_t           skid_out;
  pix_t           skid_in;
  logic           skid_push;
  logic           pop;
  logic [2:0]     occ_after;
  logic           sel_empty;
  logic           rd_issue;
  rgb565_t        rd_word;

  // NOTE: every signal driven here gets a value on every path, so no latch
  // is inferred.
  always_comb begin
    pop       = skid_vld && i_ready;
    // Slots still committed after this cycle's handshake: held entries plus
    // the datum returning from last cycle's read. Counting the departing
    // pixel lets a read issue every cycle while the consumer keeps up.
    occ_after = 3'(skid_cnt) + {2'b00, inflight_q} - {2'b00, pop};
    sel_empty = sel_q ? i_fifo2_empty : i_fifo1_empty;
    // A frame_start cycle issues nothing: the frame is being re-armed.
    rd_issue  = (state_q == ST_READ) && !i_frame_start && !sel_empty &&
                (occ_after < 3'd2);
  end

  // sel_q cannot change between issue and capture: the last read of a line
  // is captured during SWITCH, and SWITCH updates sel_q at its end.
  assign rd_word   = rgb565_t'(sel_q ? i_fifo2_rd_data : i_fifo1_rd_data);
  assign skid_in   = '{sof: infl_sof_q, eol: infl_eol_q,
                       rgb: rgb565_to_888(rd_word)};
  // The datum returning during an abort cycle belongs to the old frame.
  assign skid_push = inflight_q && !i_frame_start;

  pix_skid_buf u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (i_frame_start),
    .in_vld_i   (skid_push),
    .in_data_i  (skid_in),
    .out_vld_o  (skid_vld),
    .out_data_o (skid_out),
    .out_rdy_i  (i_ready),
    .count_o    (skid_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      sel_q        <= 1'b0;
      inflight_q   <= 1'b0;
      infl_sof_q   <= 1'b0;
      infl_eol_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      inflight_q   <= rd_issue;
      if (rd_issue) begin
        infl_sof_q <= (x_q == '0) && (y_q == '0);
        infl_eol_q <= (x_q == X_LAST);
      end

      if (i_frame_start) begin
        // Same entry from any state; an aborted frame never reports done.
        state_q <= ST_READ;
        sel_q   <= 1'b0;
        x_q     <= '0;
        y_q     <= '0;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_READ: begin
            if (rd_issue) begin
              if (x_q == X_LAST) state_q <= ST_SWITCH;
              else               x_q     <= x_q + XW'(1);
            end
          end
          ST_SWITCH: begin
            sel_q <= ~sel_q;
            x_q   <= '0;
            if (y_q == Y_LAST) begin
              state_q <= ST_DONE;
            end else begin
              y_q     <= y_q + YW'(1);
              state_q <= ST_READ;
            end
          end
          ST_DONE: begin
            // No reads remain; the handshake that empties the buffer is the
            // frame's last (eol) pixel.
            if (pop && (skid_cnt == 2'd1) && !inflight_q) begin
              frame_done_q <= 1'b1;
              state_q      <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_fifo1_rd_en = rd_issue && !sel_q;
  assign o_fifo2_rd_en = rd_issue && sel_q;
  assign o_vld         = skid_vld;
  assign o_rgb         = skid_vld ? skid_out.rgb : 24'd0;
  assign o_sof         = skid_vld && skid_out.sof;
  assign o_eol         = skid_vld && skid_out.eol;
  assign o_fifo_sel    = sel_q;
  assign o_frame_done  = frame_done_q;

endmodule
